// File: rtl/data_sram_responder.sv
// data_sram_responder: sram-like data port responder with in-order fixed-latency replies from an internal RAM
module data_sram_responder #(
  parameter int AW = 10,
  parameter int DEPTH = 2,
  parameter int LATENCY = 1,
  parameter int ACCEPT_GAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int CW = $clog2(LATENCY + DEPTH + 1);
  localparam int GW = $clog2(ACCEPT_GAP + 2);
  logic [31:0] ram [2**AW];
  logic [LATENCY-1:0] vld;
  logic [31:0] dat [LATENCY];
  logic [CW-1:0] count;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] idx;
  logic unused;
  assign unused = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};
  assign idx = data_sram_addr[AW+1:2];
  assign data_sram_addr_ok = data_sram_req & (count < CW'(DEPTH)) & (gap_cnt == '0);
  assign data_sram_data_ok = vld[LATENCY-1];
  assign data_sram_rdata = dat[LATENCY-1];
  // outstanding entries are those accepted but not yet at the output stage
  always_comb begin
    count = '0;
    for (int i = 0; i < LATENCY - 1; i++) count = count + CW'(vld[i]);
  end
  // byte-lane writes land at the handshake edge; contents are intentionally not reset
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (data_sram_addr_ok && data_sram_wr && data_sram_wstrb[b]) ram[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
  // read data is captured at accept and marched through LATENCY stages to the registered outputs
  always_ff @(posedge clk)
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
      gap_cnt <= '0;
    end else begin
      vld[0] <= data_sram_addr_ok;
      dat[0] <= (data_sram_addr_ok && !data_sram_wr) ? ram[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
      gap_cnt <= data_sram_addr_ok ? GW'(ACCEPT_GAP) : (gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: three responder configurations driven in parallel against a cycle-level reference model
module tb_data_sram_responder;
  localparam int PD [3] = '{2, 2, 3};
  localparam int PL [3] = '{1, 3, 4};
  localparam int PG [3] = '{0, 0, 2};
  logic clk = 0, reset = 1, req = 0, wr = 0;
  logic [1:0] size = 0;
  logic [3:0] strb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic aok [3];
  logic dok [3];
  logic [31:0] rd [3];
  int total = 0, bad = 0, cyc = 0;
  bit acc_h [3][16];
  bit sch_ok [3][16];
  bit [31:0] sch_d [3][16];
  bit [31:0] sch_m [3][16];
  bit [31:0] mem [3][1024];
  bit [31:0] km [3][1024];
  int last_acc [3];
  int acc_c [3];
  int ok_c [3];
  int ok_n [3];
  logic [31:0] rd_last [3];
  logic [7:0] hist [3];
  int n, s, t, w, base;
  logic ea;
  logic [31:0] m;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_responder #(.AW(10), .DEPTH(PD[g]), .LATENCY(PL[g]), .ACCEPT_GAP(PG[g])) u_dut (
      .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
      .data_sram_wstrb(strb), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_addr_ok(aok[g]), .data_sram_data_ok(dok[g]), .data_sram_rdata(rd[g]));
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cycle %0d: got=%h want=%h", nm, i, cyc, act, exp);
    end
  endtask

  // reference model: schedule each accepted request's reply L cycles after its accept cycle
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        last_acc[i] = -100;
        for (int k = 0; k < 16; k++) begin
          acc_h[i][k] = 0; sch_ok[i][k] = 0; sch_d[i][k] = 0; sch_m[i][k] = '1;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        n = 0;
        for (int k = 1; k < PL[i]; k++) n += int'(acc_h[i][(cyc - k) & 15]);
        ea = req && (n < PD[i]) && (cyc - last_acc[i] > PG[i]);
        s = cyc & 15;
        m = sch_m[i][s];
        chk("addr_ok", i, 32'(aok[i]), 32'(ea));
        chk("data_ok", i, 32'(dok[i]), 32'(sch_ok[i][s]));
        chk("rdata", i, rd[i] & m, sch_d[i][s] & m);
        sch_ok[i][s] = 0; sch_d[i][s] = 0; sch_m[i][s] = '1;
        hist[i] = {hist[i][6:0], aok[i]};
        if (aok[i]) acc_c[i] = cyc;
        if (dok[i]) begin ok_c[i] = cyc; rd_last[i] = rd[i]; ok_n[i]++; end
        acc_h[i][s] = ea;
        if (ea) begin
          last_acc[i] = cyc;
          t = (cyc + PL[i]) & 15;
          w = int'(addr[11:2]);
          sch_ok[i][t] = 1;
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (strb[b]) begin mem[i][w][8*b +: 8] = wdata[8*b +: 8]; km[i][w][8*b +: 8] = 8'hFF; end
            sch_d[i][t] = 0; sch_m[i][t] = '1;
          end else begin
            sch_d[i][t] = mem[i][w]; sch_m[i][t] = km[i][w];
          end
        end
      end
    end
    cyc++;
  end

  task automatic set_in(input bit r, input bit wv, input bit [3:0] sv, input bit [31:0] av, input bit [31:0] dv);
    req = r; wr = wv; strb = sv; addr = av; wdata = dv; size = 2'd2;
  endtask

  task automatic op(input bit wv, input bit [3:0] sv, input bit [31:0] av, input bit [31:0] dv);
    @(posedge clk); #1 set_in(1, wv, sv, av, dv);
    @(posedge clk); #1 set_in(0, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
  endtask

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    op(1, 4'hF, 32'h10, 32'hDEADBEEF);
    op(0, 4'h0, 32'h10, 32'h0);
    chk("t1_rdata", 0, rd_last[0], 32'hDEADBEEF);
    chk("t1_lat", 0, 32'(ok_c[0] - acc_c[0]), 32'd1);
    chk("t1_lat", 1, 32'(ok_c[1] - acc_c[1]), 32'd3);
    chk("t1_lat", 2, 32'(ok_c[2] - acc_c[2]), 32'd4);
    op(1, 4'hF, 32'h20, 32'h11223344);
    op(1, 4'b0100, 32'h20, 32'hAAAAAAAA);
    op(0, 4'h0, 32'h20, 32'h0);
    chk("t2_byte", 0, rd_last[0], 32'h11AA3344);
    op(1, 4'b1100, 32'h20, 32'h55665566);
    op(0, 4'h0, 32'h20, 32'h0);
    chk("t2_half", 1, rd_last[1], 32'h55663344);
    op(1, 4'hF, 32'h1004, 32'hCAFEF00D);
    chk("t6_wresp", 0, rd_last[0], 32'h0);
    op(0, 4'h0, 32'h0004, 32'h0);
    chk("t6_alias", 2, rd_last[2], 32'hCAFEF00D);
    op(1, 4'hF, 32'h30, 32'h0BADF00D);
    op(0, 4'h0, 32'h30, 32'h0);
    chk("t4_raw", 2, rd_last[2], 32'h0BADF00D);
    @(posedge clk); #1 set_in(1, 0, 0, 32'h10, 0);
    repeat (8) @(posedge clk);
    #1 set_in(0, 0, 0, 0, 0);
    chk("t3_pattern", 0, 32'(hist[0]), 32'hFF);
    chk("t3_pattern", 1, 32'(hist[1]), 32'b11011011);
    chk("t3_pattern", 2, 32'(hist[2]), 32'b10010010);
    repeat (8) @(posedge clk);
    #1 set_in(1, 0, 0, 32'h10, 0);
    @(posedge clk);
    @(posedge clk); #1 set_in(0, 0, 0, 0, 0); reset = 1; base = ok_n[1];
    @(posedge clk); #1 reset = 0; set_in(1, 0, 0, 32'h20, 0);
    @(posedge clk); #1 set_in(0, 0, 0, 0, 0);
    chk("t5_aok_after_reset", 1, 32'(hist[1][0]), 32'd1);
    repeat (6) @(posedge clk);
    chk("t5_dropped", 1, 32'(ok_n[1] - base), 32'd1);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      a = $urandom;
      a[11:6] = 6'd0;
      if (reset) set_in(0, 0, 0, 0, 0);
      else set_in($urandom_range(0, 99) < 65, 1'($urandom), 4'($urandom), a, $urandom);
    end
    @(posedge clk); #1 reset = 0; set_in(0, 0, 0, 0, 0);
    repeat (8) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
